// File: rtl/receiver_spi_if.sv
// receiver_spi_if: serial link, mode straps and parallel word port of receiver_spi
interface receiver_spi_if #(parameter int WIDTH = 8);
    logic CKP, CPH, SCK, CS, MOSI, MISO;
    logic [WIDTH-1:0] tx_data, rx_data;
    logic tx_load, rx_valid, tx_ack, frame_abort;
    modport master (
        output CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
        input  MISO, rx_data, rx_valid, tx_ack, frame_abort
    );
    modport slave (
        input  CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
        output MISO, rx_data, rx_valid, tx_ack, frame_abort
    );
endinterface

// File: rtl/receiver_spi.sv
// receiver_spi: oversampling SPI slave, all CKP/CPH modes, LSB-first, with a reply holding register
module receiver_spi #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    receiver_spi_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_q, cs_q, ckp_l, cph_l;
    logic [WIDTH-1:0] hold, tx_shift, rx_next;
    logic [WIDTH-2:0] rx_shift;
    logic [CW-1:0] bit_cnt;
    logic sck_s, cs_s, mosi_s, sck_edge, lead, trail, sample, out_edge, cs_fall, cs_rise, last;
    logic start, stop, take, shift_out;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign sck_edge = sck_s ^ sck_q;
    assign lead = sck_edge & (sck_q == ckp_l);
    assign trail = sck_edge & (sck_s == ckp_l);
    assign sample = cph_l ? trail : lead;
    assign out_edge = cph_l ? lead : trail;
    assign cs_fall = cs_q & ~cs_s;
    assign cs_rise = ~cs_q & cs_s;
    assign rx_next = {mosi_s, rx_shift};
    assign last = bit_cnt == CW'(WIDTH - 1);

    // a CS rise outranks a coincident sample edge, so the partial word is dropped
    always_comb begin
        start = 1'b0;
        stop = 1'b0;
        take = 1'b0;
        shift_out = 1'b0;
        state_n = state;
        if (state == IDLE) begin
            start = cs_fall;
            state_n = cs_fall ? ACTIVE : IDLE;
        end else begin
            stop = cs_rise;
            take = ~cs_rise & sample;
            shift_out = ~cs_rise & out_edge;
            state_n = cs_rise ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            cs_sync <= '0;
            mosi_sync <= '0;
            sck_q <= 1'b0;
            cs_q <= 1'b0;
            ckp_l <= 1'b0;
            cph_l <= 1'b0;
            hold <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt <= '0;
            bus.MISO <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.tx_ack <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            sck_q <= sck_s;
            cs_q <= cs_s;
            bus.rx_valid <= 1'b0;
            bus.tx_ack <= 1'b0;
            bus.frame_abort <= 1'b0;
            if (bus.tx_load) hold <= bus.tx_data;
            if (start) begin
                ckp_l <= bus.CKP;
                cph_l <= bus.CPH;
                bit_cnt <= '0;
                bus.tx_ack <= 1'b1;
                bus.MISO <= bus.CPH ? bus.MISO : hold[0];
                tx_shift <= bus.CPH ? hold : hold >> 1;
            end
            if (stop) begin
                bus.frame_abort <= bit_cnt != '0;
                bit_cnt <= '0;
                bus.MISO <= 1'b0;
            end
            if (take) begin
                rx_shift <= rx_next[WIDTH-1:1];
                bit_cnt <= last ? '0 : bit_cnt + CW'(1);
                if (last) begin
                    bus.rx_data <= rx_next;
                    bus.rx_valid <= 1'b1;
                    tx_shift <= hold;
                    bus.tx_ack <= 1'b1;
                end
            end
            if (shift_out) begin
                bus.MISO <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
            end
        end
    end
endmodule

// File: tb/tb_receiver_spi.sv
// tb_receiver_spi: randomized and directed SPI master driving receiver_spi against a word-level model
module tb_receiver_spi;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    receiver_spi_if #(.WIDTH(W)) bus();
    receiver_spi #(.WIDTH(W), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rx = 0, n_ack = 0, n_abort = 0, cs_hi = 0;
    logic prev_rv = 1'b0, prev_ack = 1'b0, prev_ab = 1'b0;
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] model_rx = '0;
    logic [W-1:0] ack_q[$];
    logic [W-1:0] fw[4];
    logic [W-1:0] fm[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // every cycle: received word stream, pulse widths and idle MISO
    always @(negedge clk) begin
        if (rst) begin
            exp_rx.delete();
            model_rx = '0;
            cs_hi = 0;
        end else begin
            if (bus.rx_valid) begin
                n_rx++;
                checks++;
                if (exp_rx.size() == 0) begin
                    errors++;
                    $display("FAIL rx_valid_unexpected: got pulse with rx_data %0h, expected none", bus.rx_data);
                end else model_rx = exp_rx.pop_front();
            end
            check("rx_data", bus.rx_data, model_rx);
            if (bus.tx_ack) n_ack++;
            if (bus.frame_abort) n_abort++;
            check("pulse_width", {29'd0, bus.rx_valid & prev_rv, bus.tx_ack & prev_ack, bus.frame_abort & prev_ab}, 0);
            cs_hi = bus.CS ? cs_hi + 1 : 0;
            if (cs_hi > 6) check("miso_idle", bus.MISO, 0);
        end
        prev_rv = bus.rx_valid;
        prev_ack = bus.tx_ack;
        prev_ab = bus.frame_abort;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            bus.tx_load = 1'b0;
            if (ack_q.size() > 0 && bus.tx_ack) begin
                bus.tx_data = ack_q.pop_front();
                bus.tx_load = 1'b1;
            end
        end
    endtask

    task automatic load(input logic [W-1:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick();
    endtask

    function automatic logic fbit(input int j);
        logic [W-1:0] w;
        w = fw[j / W];
        return w[j % W];
    endfunction

    // a collision load lands on the clk edge that acts on the last sample edge of word cw
    task automatic sample_wait(input int j, input int cw);
        if (j == cw * W + W - 1) begin
            tick(2);
            bus.tx_data = 8'hEE;
            bus.tx_load = 1'b1;
            tick(1);
        end else tick(2);
    endtask

    task automatic run_frame(input logic ckp, input logic cph, input int nw, input int lastb,
                             input bit raise, input int cw);
        int nb, nfull, ack0, rx0, ab0;
        logic cap[$];
        logic [W-1:0] got;
        nb = (nw - 1) * W + lastb;
        nfull = (lastb == W) ? nw : nw - 1;
        ack0 = n_ack;
        rx0 = n_rx;
        ab0 = n_abort;
        bus.CKP = ckp;
        bus.CPH = cph;
        bus.SCK = ckp;
        tick(4);
        for (int w = 0; w < nfull; w++) exp_rx.push_back(fw[w]);
        bus.CS = 1'b0;
        bus.MOSI = fbit(0);
        tick(4);
        for (int j = 0; j < nb; j++) begin
            if (cph) begin
                if (j > 0) cap.push_back(bus.MISO);
                bus.MOSI = fbit(j);
                bus.SCK = ~ckp;
                tick(2);
                bus.SCK = ckp;
                sample_wait(j, cw);
            end else begin
                bus.SCK = ~ckp;
                sample_wait(j, cw);
                cap.push_back(bus.MISO);
                bus.SCK = ckp;
                if (j + 1 < nb) bus.MOSI = fbit(j + 1);
                tick(2);
            end
        end
        tick(2);
        if (cph) cap.push_back(bus.MISO);
        check("miso_bit_count", cap.size(), nb);
        for (int w = 0; w < nfull; w++) begin
            for (int i = 0; i < W; i++) got[i] = cap[w * W + i];
            check("miso_word", got, fm[w]);
        end
        if (raise) begin
            bus.CS = 1'b1;
            tick(6);
            check("rx_valid_count", n_rx - rx0, nfull);
            check("tx_ack_count", n_ack - ack0, nfull + 1);
            check("abort_count", n_abort - ab0, (lastb != W) ? 1 : 0);
            check("rx_pending", exp_rx.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        int m, nw;
        bus.CS = 1'b1;
        bus.SCK = 1'b0;
        bus.MOSI = 1'b0;
        bus.CKP = 1'b0;
        bus.CPH = 1'b0;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        tick(3);
        #1;
        check("reset_miso", bus.MISO, 0);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_tx_ack", bus.tx_ack, 0);
        check("reset_frame_abort", bus.frame_abort, 0);
        tick();
        rst = 1'b0;
        tick(4);

        load(8'hA5);
        fw[0] = 8'h3C;
        fm[0] = 8'hA5;
        run_frame(1'b0, 1'b0, 1, W, 1'b1, -1);
        check("mode0_rx", bus.rx_data, 8'h3C);

        load(8'h5A);
        fw[0] = 8'h81; fw[1] = 8'h7E; fw[2] = 8'h00; fw[3] = 8'hFF;
        for (int i = 0; i < 4; i++) fm[i] = 8'h5A;
        for (int md = 0; md < 4; md++) begin
            run_frame(md[1], md[0], 4, W, 1'b1, -1);
            check("modes_last_rx", bus.rx_data, 8'hFF);
        end

        load(8'hC1);
        ack_q.push_back(8'hC2);
        ack_q.push_back(8'hC3);
        fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
        fm[0] = 8'hC1; fm[1] = 8'hC2; fm[2] = 8'hC3;
        run_frame(1'b0, 1'b0, 3, W, 1'b1, -1);
        check("frame24_last_rx", bus.rx_data, 8'h33);

        fw[0] = 8'hFF;
        run_frame(1'b0, 1'b0, 1, 5, 1'b1, -1);
        check("abort_rx_kept", bus.rx_data, 8'h33);
        fw[0] = 8'h96;
        fm[0] = 8'hC3;
        run_frame(1'b0, 1'b0, 1, W, 1'b1, -1);
        check("after_abort_rx", bus.rx_data, 8'h96);

        load(8'h5A);
        fw[0] = 8'h01; fw[1] = 8'h02; fw[2] = 8'h03;
        fm[0] = 8'h5A; fm[1] = 8'h5A; fm[2] = 8'hEE;
        run_frame(1'b0, 1'b0, 3, W, 1'b1, 0);

        load(8'h77);
        fw[0] = 8'h42;
        run_frame(1'b0, 1'b0, 1, 3, 1'b0, -1);
        tick();
        #1 rst = 1'b1;
        #1;
        check("midreset_miso", bus.MISO, 0);
        check("midreset_rx_data", bus.rx_data, 0);
        check("midreset_rx_valid", bus.rx_valid, 0);
        check("midreset_tx_ack", bus.tx_ack, 0);
        check("midreset_frame_abort", bus.frame_abort, 0);
        tick(2);
        bus.CS = 1'b1;
        bus.SCK = 1'b0;
        tick();
        rst = 1'b0;
        tick(8);
        load(8'h24);
        fm[0] = 8'h24;
        run_frame(1'b0, 1'b0, 1, W, 1'b1, -1);
        check("after_reset_rx", bus.rx_data, 8'h42);

        for (int f = 0; f < 30; f++) begin
            v = W'($urandom);
            m = $urandom_range(0, 3);
            nw = $urandom_range(1, 3);
            load(v);
            for (int i = 0; i < nw; i++) begin
                fw[i] = W'($urandom);
                fm[i] = v;
            end
            run_frame(m[1], m[0], nw, W, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
